// File: rtl/gate_selftest_pkg.sv
// Shared types and constants for the two-input gate self-test controller.
// Bit positions of y_in match the golden vector produced by gate_expect.
package gate_selftest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_NOT  = 2;
    localparam int IDX_NOR  = 3;
    localparam int IDX_XOR  = 4;
    localparam int IDX_XNOR = 5;

    localparam int RES_W   = 6;
    localparam int NUM_VEC = 4;

endpackage

// File: rtl/gate_selftest_ctrl_if.sv
// Operand/result bus between the self-test controller and the gate block under test.
// master = controller (drives operands), slave = gate block (returns results).
interface gate_selftest_ctrl_if;
    import gate_selftest_pkg::*;

    logic             a;
    logic             b;
    logic [RES_W-1:0] y_in;

    modport master (output a, output b, input y_in);
    modport slave  (input a, input b, output y_in);

endinterface

// File: rtl/gate_expect.sv
// Golden result vector for one (a, b) operand pair, purely combinational.
module gate_expect
    import gate_selftest_pkg::*;
(
    input  logic             a,
    input  logic             b,
    output logic [RES_W-1:0] y
);

    always_comb begin
        y           = '0;
        y[IDX_AND]  = a & b;
        y[IDX_OR]   = a | b;
        y[IDX_NOT]  = ~a;
        y[IDX_NOR]  = ~(a | b);
        y[IDX_XOR]  = a ^ b;
        y[IDX_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Sweeps the four (a,b) operand pairs through a gate block, waits SETTLE_CYC cycles per
// vector and accumulates mismatches into err_cnt / fail_mask.
module gate_selftest_ctrl
    import gate_selftest_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter bit LOOP_EN    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    gate_selftest_ctrl_if.master      gbus,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [2:0]                err_cnt,
    output logic [RES_W-1:0]          fail_mask,
    output logic [1:0]                vec_idx,
    output state_t                    fsm_state
);

    // Handshake: start is a request sampled only in IDLE/DONE; busy is high from the cycle
    // after acceptance until the last CHECK; done/pass/err_cnt/fail_mask are valid while done=1.

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VEC - 1);
    localparam logic [2:0] ERR_MAX     = 3'(NUM_VEC);

    state_t           state;
    logic [7:0]       settle_cnt;
    logic             a_q;
    logic             b_q;
    logic [RES_W-1:0] golden;
    logic [RES_W-1:0] mismatch;
    logic [RES_W-1:0] mask_next;
    logic [2:0]       err_next;
    logic [1:0]       vec_next;

    gate_expect u_expect (
        .a (a_q),
        .b (b_q),
        .y (golden)
    );

    assign mismatch  = gbus.y_in ^ golden;
    assign mask_next = fail_mask | mismatch;
    assign vec_next  = vec_idx + 2'd1;

    // Saturating count of failing vectors.
    always_comb begin
        err_next = err_cnt;
        if ((|mismatch) && (err_cnt < ERR_MAX)) begin
            err_next = err_cnt + 3'd1;
        end
    end

    assign gbus.a    = a_q;
    assign gbus.b    = b_q;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            vec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_APPLY;
                        busy      <= 1'b1;
                        vec_idx   <= '0;
                        err_cnt   <= '0;
                        fail_mask <= '0;
                        a_q       <= 1'b0;
                        b_q       <= 1'b0;
                    end
                end

                ST_APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end

                ST_CHECK: begin
                    err_cnt   <= err_next;
                    fail_mask <= mask_next;
                    if (vec_idx == LAST_VEC) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 3'd0);
                    end else begin
                        // Operands change only here, so they hold from APPLY through CHECK.
                        vec_idx <= vec_next;
                        a_q     <= vec_next[1];
                        b_q     <= vec_next[0];
                        state   <= ST_APPLY;
                    end
                end

                ST_DONE: begin
                    if (start || LOOP_EN) begin
                        state     <= ST_APPLY;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        vec_idx   <= '0;
                        err_cnt   <= '0;
                        fail_mask <= '0;
                        a_q       <= 1'b0;
                        b_q       <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Directed bench: three controller instances (SETTLE_CYC=4, looping SETTLE_CYC=4,
// SETTLE_CYC=1), each driven by a gate model with a selectable fault.
module tb_gate_selftest_ctrl;
    import gate_selftest_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1, start2;

    logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [2:0] err0, err1, err2;
    logic [5:0] mask0, mask1, mask2;
    logic [1:0] vec0, vec1, vec2;
    state_t     st0, st1, st2;

    int mode0 = 0;
    int mode1 = 0;
    int mode2 = 0;
    int total = 0;
    int bad   = 0;

    gate_selftest_ctrl_if bus0 ();
    gate_selftest_ctrl_if bus1 ();
    gate_selftest_ctrl_if bus2 ();

    always #5 clk = ~clk;

    // mode 0: correct gates, 1: xor stuck at 0, 2: every output inverted
    function automatic logic [5:0] gate_model(input logic a, input logic b, input int mode);
        logic [5:0] y;
        y = {~(a ^ b), a ^ b, ~(a | b), ~a, a | b, a & b};
        if (mode == 1) y[4] = 1'b0;
        if (mode == 2) y = ~y;
        return y;
    endfunction

    assign bus0.y_in = gate_model(bus0.a, bus0.b, mode0);
    assign bus1.y_in = gate_model(bus1.a, bus1.b, mode1);
    assign bus2.y_in = gate_model(bus2.a, bus2.b, mode2);

    gate_selftest_ctrl #(.SETTLE_CYC(4), .LOOP_EN(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .gbus(bus0.master),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_mask(mask0), .vec_idx(vec0), .fsm_state(st0)
    );

    gate_selftest_ctrl #(.SETTLE_CYC(4), .LOOP_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .gbus(bus1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_mask(mask1), .vec_idx(vec1), .fsm_state(st1)
    );

    gate_selftest_ctrl #(.SETTLE_CYC(1), .LOOP_EN(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start2), .gbus(bus2.master),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_mask(mask2), .vec_idx(vec2), .fsm_state(st2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start on u0, optionally re-pulses it inject_at cycles later, counts cycles to done.
    task automatic run_sweep0(input int inject_at, output int cycles);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        cycles = 0;
        while (done0 !== 1'b1 && cycles < 200) begin
            start0 = (cycles == inject_at);
            @(posedge clk);
            #1;
            cycles++;
        end
        start0 = 1'b0;
        chk("sweep_reached_done", {31'd0, done0}, 32'd1);
    endtask

    initial begin
        int n;
        int k;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", st0, ST_IDLE);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_mask", mask0, 0);
        chk("rst_vec", vec0, 0);
        chk("rst_ab", {bus0.a, bus0.b}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_without_start", st0, ST_IDLE);

        // Clean sweep
        mode0 = 0;
        run_sweep0(-1, n);
        chk("clean_cycles", n, 24);
        chk("clean_pass", pass0, 1);
        chk("clean_err", err0, 0);
        chk("clean_mask", mask0, 6'h00);
        chk("clean_vec", vec0, 3);

        // xor stuck at 0: vectors 01 and 10 fail
        mode0 = 1;
        run_sweep0(-1, n);
        chk("xor_cycles", n, 24);
        chk("xor_err", err0, 2);
        chk("xor_mask", mask0, 6'b010000);
        chk("xor_pass", pass0, 0);
        repeat (3) @(negedge clk);
        chk("done_hold", done0, 1);
        chk("done_hold_err", err0, 2);
        chk("done_hold_mask", mask0, 6'b010000);

        // All outputs inverted
        mode0 = 2;
        run_sweep0(-1, n);
        chk("inv_err", err0, 4);
        chk("inv_mask", mask0, 6'b111111);
        chk("inv_pass", pass0, 0);

        // start pulsed while busy
        mode0 = 0;
        run_sweep0(5, n);
        chk("busy_start_cycles", n, 24);
        chk("busy_start_pass", pass0, 1);
        chk("busy_start_err", err0, 0);

        // Reset during SETTLE of vector 2
        mode0 = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        while (!(st0 == ST_SETTLE && vec0 == 2'd2) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_settle_v2", st0, ST_SETTLE);
        chk("pre_rst_err", err0, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_state", st0, ST_IDLE);
        chk("async_rst_busy", busy0, 0);
        chk("async_rst_err", err0, 0);
        chk("async_rst_mask", mask0, 0);
        chk("async_rst_vec", vec0, 0);
        chk("async_rst_ab", {bus0.a, bus0.b}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", st0, ST_IDLE);
        mode0 = 0;
        run_sweep0(-1, n);
        chk("post_rst_cycles", n, 24);
        chk("post_rst_pass", pass0, 1);

        // LOOP_EN=1 restarts one cycle after DONE with results cleared
        mode1 = 2;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("loop_cycles", n, 24);
        chk("loop_done_err", err1, 4);
        @(posedge clk);
        #1;
        chk("loop_restart_state", st1, ST_APPLY);
        chk("loop_restart_done", done1, 0);
        chk("loop_restart_busy", busy1, 1);
        chk("loop_restart_err", err1, 0);
        chk("loop_restart_mask", mask1, 0);

        // SETTLE_CYC=1: 3 cycles per vector, operands stable within each window
        mode2 = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (k = 0; k < 12; k++) begin
            chk("s1_a", bus2.a, (k / 3) >> 1);
            chk("s1_b", bus2.b, (k / 3) & 1);
            chk("s1_state", st2, (k % 3 == 0) ? ST_APPLY : (k % 3 == 1) ? ST_SETTLE : ST_CHECK);
            @(posedge clk);
            #1;
        end
        chk("s1_done", done2, 1);
        chk("s1_pass", pass2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_selftest_ctrl.md
GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4: cycles waited between driving a vector and sampling results (legal range 1..255).
REQ-002 SHALL have parameter LOOP_EN, default 0: 1 = restart the sweep automatically after DONE.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begins one truth-table sweep; sampled only in IDLE or DONE.
REQ-006 SHALL have port a, output, 1: operand A driven to the gate block under test.
REQ-007 SHALL have port b, output, 1: operand B driven to the gate block under test.
REQ-008 SHALL have port y_in, input, 6: results from the gate block under test, ordered [0]=and, [1]=or, [2]=not(a), [3]=nor, [4]=xor, [5]=xnor.
REQ-009 SHALL have port busy, output, 1: high in APPLY, SETTLE and CHECK.
REQ-010 SHALL have port done, output, 1: high while in DONE.
REQ-011 SHALL have port pass, output, 1: valid when done=1; 1 iff err_cnt==0.
REQ-012 SHALL have port err_cnt, output, 3: number of vectors with at least one mismatching bit, 0..4.
REQ-013 SHALL have port fail_mask, output, 6: sticky OR of mismatching y_in bit positions across the sweep.
REQ-014 SHALL have port vec_idx, output, 2: current vector index; a = vec_idx[1], b = vec_idx[0].

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-016 IDLE→APPLY on start=1; SHALL clear vec_idx, err_cnt and fail_mask on this transition.
REQ-017 APPLY SHALL last one cycle, drive a/b from vec_idx, load the settle counter with SETTLE_CYC-1, then go to SETTLE.
REQ-018 SETTLE SHALL decrement the counter each cycle and go to CHECK in the cycle after it reaches 0. Total APPLY-to-CHECK delay SHALL be SETTLE_CYC+1 cycles.
REQ-019 CHECK SHALL last one cycle and compare y_in to the expected vector for the current a,b.
REQ-020 CHECK SHALL increment err_cnt if any bit differs, and OR the differing bits into fail_mask.
REQ-021 From CHECK: if vec_idx<3, SHALL increment vec_idx and go to APPLY; if vec_idx==3, SHALL go to DONE.
REQ-022 One sweep SHALL take exactly 4×(SETTLE_CYC+2) cycles from leaving IDLE to entering DONE.
REQ-023 DONE SHALL hold err_cnt, fail_mask and pass stable.
REQ-024 DONE→APPLY on start=1, or unconditionally after one cycle when LOOP_EN=1; the clears of REQ-016 SHALL apply.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 a and b SHALL be registered outputs and SHALL hold constant from APPLY through CHECK of each vector.
REQ-027 err_cnt SHALL never exceed 4; no wrap.

Reset
REQ-028 On rst=1, regardless of clk or current state, SHALL immediately force: state=IDLE, a=0, b=0, vec_idx=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, settle counter=0.
REQ-029 Reset asserted mid-sweep SHALL abandon the sweep; after release the block stays in IDLE until start=1.

Structure
REQ-030 A shared package gate_selftest_pkg SHALL hold the state enum, the y_in bit-index constants (IDX_AND..IDX_XNOR) and the constant NUM_VEC=4.
REQ-031 The expected-result computation SHALL be a combinational sub-module gate_expect (inputs a, b; output 6-bit golden vector), instantiated once.

Verification
REQ-032 Connect a correct gate model, SETTLE_CYC=4, pulse start → done=1 after 24 cycles, pass=1, err_cnt=0, fail_mask=6'b000000.
REQ-033 Force y_in[4] (xor) stuck at 0 → err_cnt=2 (vectors 01, 10), fail_mask=6'b010000, pass=0.
REQ-034 Invert all y_in → err_cnt=4, fail_mask=6'b111111.
REQ-035 Assert rst during SETTLE of vector 2 → all outputs take reset values without waiting for clk; a subsequent start gives a full 24-cycle sweep.
REQ-036 Pulse start while busy=1 → no effect on sweep timing or results; LOOP_EN=1 → a new APPLY begins one cycle after DONE, with err_cnt cleared.
REQ-037 SETTLE_CYC=1 → sweep takes 12 cycles, and a/b are stable across each APPLY..CHECK window.
